// File: rtl/timer_scheduler_pkg.sv
// Shared types and helpers for timer_scheduler: FSM state encoding, one-hot decode
// and the default prescale ratio.
package timer_sched_pkg;

    localparam int DEFAULT_PRESCALE = 4;
    localparam int MAX_NREQ         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: picks the first set request at or after ptr_i, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   winner_o,
    output logic            valid_o
);

    always_comb begin
        int idx;
        winner_o = '0;
        valid_o  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_i) + i) % NREQ;
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one W-bit cycle timer among NREQ round-robin requesters and pulses done on expiry.
// Optional macro TIMER_SCHED_PRESCALE_EN: timer advances once every PRESCALE clk cycles.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req,
    input  logic [NREQ*W-1:0]                 dur,
    output logic [NREQ-1:0]                   gnt,
    output logic [NREQ-1:0]                   done,
    output logic                              busy,
    output logic [((NREQ>1)?$clog2(NREQ):1)-1:0] owner,
    output logic [W-1:0]                      count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t    state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    max_q, max_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [IW-1:0]   winner;
    logic            win_valid;
    logic [IW-1:0]   ptr_next;
    logic            tick;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .valid_o  (win_valid)
    );

    assign ptr_next = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);

`ifdef TIMER_SCHED_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] presc_q, presc_d;

    assign tick = (presc_q == PS_W'(PRESCALE - 1));

    always_comb begin
        presc_d = presc_q;
        if (state_q == IDLE) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch;
    // blocking '=' here, non-blocking '<=' only in the clocked process.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        max_d   = max_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = winner;
                    max_d   = dur[int'(winner)*W +: W];
                    count_d = '0;
                    gnt_d   = NREQ'(onehot(3'(winner)));
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                    ptr_d   = ptr_next;
                end else if (tick) begin
                    if (count_q == max_q) begin
                        state_d = DONE;
                        done_d  = gnt_q;
                    end else begin
                        count_d = count_q + W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                count_d = '0;
                ptr_d   = ptr_next;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // NOTE: asynchronous reset clears all control state immediately, so an aborted
    // timeout can never leave a stale done pulse behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            max_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            max_q   <= max_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign owner = owner_q;
    assign count = count_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed scenarios plus a randomized run
// against an elapsed-time reference model of the scheduling rules.
module tb_timer_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
`ifdef TIMER_SCHED_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] dur;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [1:0]        owner;
    logic [W-1:0]      count;

    int n_tests = 0;
    int n_fail  = 0;

    timer_scheduler #(.NREQ(NREQ), .W(W), .PRESCALE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dur   (dur),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .owner (owner),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dur(input int idx, input int val);
        dur[idx*W +: W] = W'(val);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        dur = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        dur = '0;
        cyc();
        n_tests++;
        if ({gnt, done, busy, owner, count} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: gnt=%b done=%b busy=%b owner=%0d count=%0d, expected all 0",
                     gnt, done, busy, owner, count);
        end
        rst = 1'b0;
    endtask

    // Grant idx with duration d and check every cycle through done and release.
    task automatic serve_and_check(input int idx, input int d, input string name);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << idx;
        do_reset();
        set_dur(idx, d);
        req = oh;
        for (int k = 0; k < (d + 1) * P; k++) begin
            cyc();
            set_dur(idx, 200);
            n_tests++;
            if (gnt !== oh || done !== '0 || busy !== 1'b1 || count !== W'(k / P) || owner !== 2'(idx)) begin
                n_fail++;
                $display("FAIL %s_run k=%0d: gnt=%b done=%b busy=%b count=%0d owner=%0d, expected gnt=%b done=0 busy=1 count=%0d owner=%0d",
                         name, k, gnt, done, busy, count, owner, oh, k / P, idx);
            end
        end
        cyc();
        n_tests++;
        if (done !== oh || gnt !== oh || count !== W'(d)) begin
            n_fail++;
            $display("FAIL %s_done: done=%b gnt=%b count=%0d, expected done=%b gnt=%b count=%0d",
                     name, done, gnt, count, oh, oh, d);
        end
        req = '0;
        cyc();
        n_tests++;
        if (done !== '0 || gnt !== '0 || busy !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL %s_release: done=%b gnt=%b busy=%b count=%0d, expected all 0",
                     name, done, gnt, busy, count);
        end
    endtask

    task automatic test_single();
        serve_and_check(1, 3, "single");
    endtask

    task automatic test_zero_dur();
        serve_and_check(2, 0, "zero_dur");
    endtask

`ifdef TIMER_SCHED_PRESCALE_EN
    task automatic test_prescale();
        serve_and_check(0, 2, "prescale");
    endtask
`endif

    task automatic test_reset_mid_run();
        bit found = 1'b0;
        bit saw_done = 1'b0;
        do_reset();
        set_dur(2, 5);
        req = 4'b0100;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            if (count == 8'd3) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid_run_reach: count never reached 3");
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({gnt, done, busy, owner, count} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run_async: gnt=%b done=%b busy=%b owner=%0d count=%0d, expected all 0",
                     gnt, done, busy, owner, count);
        end
        cyc();
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (done !== '0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_mid_run_quiet: activity seen after reset, expected idle with no done");
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int last = 0;
        logic [NREQ-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_dur(i, 1);
        req = 4'b1111;
        for (int c = 0; c < 200 && n < 5; c++) begin
            cyc();
            if (done !== '0) begin
                exp_oh = NREQ'(1) << (n % NREQ);
                n_tests++;
                if (done !== exp_oh) begin
                    n_fail++;
                    $display("FAIL rr_order #%0d: done=%b, expected %b", n, done, exp_oh);
                end
                if (n > 0) begin
                    n_tests++;
                    if (c - last != 2 * P + 2) begin
                        n_fail++;
                        $display("FAIL rr_spacing #%0d: %0d cycles, expected %0d", n, c - last, 2 * P + 2);
                    end
                end
                last = c;
                n++;
            end
        end
        n_tests++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL rr_count: saw %0d done pulses, expected 5", n);
        end
        req = '0;
        cyc();
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        bit saw_done = 1'b0;
        do_reset();
        set_dur(0, 10);
        set_dur(1, 2);
        req = 4'b0011;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (done !== '0) saw_done = 1'b1;
            if (count == 8'd4) found = 1'b1;
        end
        n_tests++;
        if (!found || saw_done || gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_setup: found=%0d saw_done=%0d gnt=%b, expected 1 0 0001", found, saw_done, gnt);
        end
        req = 4'b0010;
        cyc();
        n_tests++;
        if (gnt !== '0 || done !== '0 || busy !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: gnt=%b done=%b busy=%b count=%0d, expected all 0", gnt, done, busy, count);
        end
        cyc();
        n_tests++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || done !== '0) begin
            n_fail++;
            $display("FAIL abort_next_grant: gnt=%b owner=%0d done=%b, expected gnt=0010 owner=1 done=0000",
                     gnt, owner, done);
        end
        req = '0;
        cyc();
    endtask

    task automatic test_random();
        bit m_srv = 1'b0;
        int m_own = 0;
        int m_ptr = 0;
        int m_k = 0;
        int m_len = 0;
        int exp_cnt;
        logic [NREQ-1:0] exp_gnt, exp_done;
        bit found;
        int idx;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            exp_gnt  = m_srv ? NREQ'(1) << m_own : '0;
            exp_done = (m_srv && m_k == (m_len + 1) * P) ? NREQ'(1) << m_own : '0;
            exp_cnt  = !m_srv ? 0 : ((m_k / P < m_len) ? m_k / P : m_len);
            n_tests++;
            if (gnt !== exp_gnt || done !== exp_done || busy !== m_srv || owner !== 2'(m_own) || count !== W'(exp_cnt)) begin
                n_fail++;
                $display("FAIL random c=%0d: gnt=%b done=%b busy=%b owner=%0d count=%0d, expected gnt=%b done=%b busy=%b owner=%0d count=%0d",
                         c, gnt, done, busy, owner, count, exp_gnt, exp_done, m_srv, m_own, exp_cnt);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if ((exp_done[i] && $urandom_range(1, 0) == 0) || $urandom_range(59, 0) == 0) req[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                end
                set_dur(i, ($urandom_range(9, 0) == 0) ? $urandom_range(20, 8) : $urandom_range(5, 0));
            end
            if (!m_srv) begin
                found = 1'b0;
                for (int j = 0; j < NREQ; j++) begin
                    idx = (m_ptr + j) % NREQ;
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        m_srv = 1'b1;
                        m_own = idx;
                        m_len = int'(dur[idx*W +: W]);
                        m_k   = 0;
                    end
                end
            end else if (m_k == (m_len + 1) * P || !req[m_own]) begin
                m_srv = 1'b0;
                m_ptr = (m_own + 1) % NREQ;
            end else begin
                m_k++;
            end
            cyc();
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_single();
        test_zero_dur();
        test_round_robin();
        test_abort();
`ifdef TIMER_SCHED_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
